// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, builds the four next-PC candidates and the mux-bank select.
// Optional misaligned-target trap is enabled by defining MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_branch_taken,
  input  logic             i_jump_en,
  input  logic             i_jr_en,
  input  logic [WIDTH-1:0] i_imm_offset,
  input  logic [25:0]      i_jump_index,
  input  logic [WIDTH-1:0] i_reg_target,
  input  logic             i_stall,
  input  logic             i_halt_req,
  input  logic             i_resume,
  input  logic [WIDTH-1:0] i_next_pc,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic [WIDTH-1:0] o_branch_target,
  output logic [WIDTH-1:0] o_jump_addr,
  output logic [WIDTH-1:0] o_reg_addr,
  output logic [1:0]       o_pc_select,
  output logic [1:0]       o_state,
`ifdef MISALIGN_TRAP_EN
  output logic             o_misalign,
`endif
  output logic [15:0]      o_retired_cnt
);

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StRun   = 2'b01,
    StStall = 2'b10,
    StHalt  = 2'b11
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [15:0]      r_retired_cnt;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [1:0]       w_pc_select;

  assign w_pc_plus4      = r_pc + WIDTH'(4);
  assign o_pc            = r_pc;
  assign o_pc_plus4      = w_pc_plus4;
  assign o_branch_target = w_pc_plus4 + (i_imm_offset << 2);
  assign o_jump_addr     = {w_pc_plus4[WIDTH-1:28], i_jump_index, 2'b00};
  assign o_reg_addr      = i_reg_target;
  assign o_pc_select     = w_pc_select;
  assign o_state         = r_state;
  assign o_retired_cnt   = r_retired_cnt;

  // Select stays sequential while booting or halted so the bank never sees a stale redirect.
  always_comb begin
    w_pc_select = 2'b00;
    if (r_state == StRun || r_state == StStall) begin
      if (i_jr_en)             w_pc_select = 2'b11;
      else if (i_jump_en)      w_pc_select = 2'b10;
      else if (i_branch_taken) w_pc_select = 2'b01;
      else                     w_pc_select = 2'b00;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_np_misaligned;

  assign w_np_misaligned = |i_next_pc[1:0];
  assign o_misalign      = r_misalign;
`else
  logic [1:0] w_unused_np_low;

  assign w_unused_np_low = i_next_pc[1:0];
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= StBoot;
      r_pc          <= RESET_VECTOR;
      r_retired_cnt <= '0;
`ifdef MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      case (r_state)
        // RESET_VECTOR gets exactly one fetch cycle before the first update.
        StBoot: r_state <= StRun;
        StRun: begin
          if (i_halt_req) begin
            r_state <= StHalt;
          end else if (i_stall) begin
            r_state <= StStall;
          end else begin
`ifdef MISALIGN_TRAP_EN
            if (w_np_misaligned) begin
              r_state    <= StHalt;
              r_misalign <= 1'b1;
            end else begin
              r_pc          <= i_next_pc;
              r_retired_cnt <= r_retired_cnt + 16'd1;
            end
`else
            r_pc          <= {i_next_pc[WIDTH-1:2], 2'b00};
            r_retired_cnt <= r_retired_cnt + 16'd1;
`endif
          end
        end
        // Leaving STALL never updates the PC on the same edge.
        StStall: begin
          if (i_halt_req)    r_state <= StHalt;
          else if (!i_stall) r_state <= StRun;
        end
        StHalt: begin
          if (i_resume) begin
`ifdef MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            if (!i_halt_req) r_state <= StRun;
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

endmodule
